sync_fifo_buffer: RTL and testbench
===================================

Name: sync_fifo_buffer

Overview:
- Single-clock, synchronous first-in-first-out buffer of fifo_depth words, each fifo_width bits.
- The producer pushes with fifo_write when fifo_full is low.
- The consumer pops with fifo_read when fifo_empty is low and gets the popped word on fifo_data_out one cycle later.
- The block is used as a generic elastic buffer between two handshake interfaces in the same clock domain.

Parameters:
- fifo_depth, 8, number of storage entries. Must be a power of two, ≥ 2.
- fifo_width, 8, data word width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rstn  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- fifo_data_in  input  fifo_width  write data, sampled when a write is accepted.
- fifo_write  input  1  write request.
- fifo_full  output  1  high when the buffer holds fifo_depth entries.
- fifo_read  input  1  read request.
- fifo_empty  output  1  high when the buffer holds 0 entries.
- fifo_data_out  output  fifo_width  registered read data.
- fifo_count  output  log2(fifo_depth)+1  current occupancy. May be left unconnected.

Behaviour:
- Reset (rstn=0 at a clk rising edge):
  - write pointer, read pointer and count go to 0.
  - fifo_empty=1, fifo_full=0, fifo_data_out=0, fifo_count=0.
  - Memory contents are not cleared.
  - Reset wins over any simultaneous read or write; a mid-operation reset discards all stored data.
- Accept rules, evaluated on the registered flags at the clock edge:
  - write accepted = fifo_write & ~fifo_full.
  - read accepted = fifo_read & ~fifo_empty.
- Accepted write: mem[wr_ptr] <= fifo_data_in; wr_ptr increments modulo fifo_depth (natural wrap at the log2(fifo_depth)-bit width).
- Accepted read:
  - fifo_data_out <= mem[rd_ptr]; rd_ptr increments modulo fifo_depth.
  - Read latency is 1 cycle: data is valid on the cycle after the edge where fifo_read is sampled.
- No accepted read: fifo_data_out holds its previous value.
- Rejected operations (write when full, read when empty) are silently dropped. Pointers, count, memory and fifo_data_out are unchanged.
- Count update:
  - +1 on write-only.
  - −1 on read-only.
  - Unchanged on both or neither.
- Flags, registered and derived from the next count:
  - fifo_empty = (count_next == 0).
  - fifo_full = (count_next == fifo_depth).
  - Both flags change in the same cycle as the count.
- Simultaneous write and read:
  - Neither flag set: both are accepted, count is unchanged.
  - fifo_full=1: only the read is accepted; the write is dropped and the count goes to fifo_depth−1.
  - fifo_empty=1: only the write is accepted; the read is dropped, fifo_data_out holds and the count goes to 1. There is no write-through bypass.
- Ordering: words leave in exactly the order they were accepted, across any number of pointer wraps.
- fifo_full and fifo_empty are never high at the same time.
- X on fifo_data_in is stored as-is; control inputs are assumed to be known (non-X) after reset.

Test Plan:
- Reset check: hold rstn=0 for 2 cycles -> fifo_empty=1, fifo_full=0, fifo_data_out=0, fifo_count=0. Release rstn -> state stays unchanged until a write is accepted.
- Fill and drain:
  - Write 0x01..0x08 on consecutive cycles -> fifo_empty falls after the first write, fifo_full rises after the 8th write.
  - Then read 8 times -> fifo_data_out shows 0x01..0x08, each one cycle after its read; fifo_empty rises after the 8th read.
- Overflow: with the buffer full, write 0xAA -> it is dropped, fifo_full stays 1, and a full drain returns the original 8 words only.
- Underflow: with the buffer empty, assert fifo_read -> fifo_data_out holds its last value, fifo_empty stays 1, fifo_count stays 0.
- Simultaneous operations:
  - With 3 words stored, assert write 0x55 and read together for 4 cycles -> fifo_count stays 3 and data emerges in FIFO order.
  - When full, write+read together -> the read pops and fifo_full drops.
  - When empty, write+read together -> 1 entry is stored and fifo_data_out is unchanged.
- Wrap and mid-operation reset:
  - Stream 20 random words with random write/read gaps -> output order matches a reference queue.
  - Assert rstn=0 with 5 words stored -> empty=1, count=0, and subsequent reads are ignored.

Source files
------------

// File: rtl/sync_fifo_buffer.sv
// Single-clock FIFO with registered read data, registered full/empty flags and occupancy count.
// Flags are computed from the next count so they change in the same cycle as fifo_count.
module sync_fifo_buffer #(
  parameter int unsigned fifo_depth = 8,
  parameter int unsigned fifo_width = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [fifo_width-1:0]         fifo_data_in,
  input  logic                          fifo_write,
  output logic                          fifo_full,
  input  logic                          fifo_read,
  output logic                          fifo_empty,
  output logic [fifo_width-1:0]         fifo_data_out,
  output logic [$clog2(fifo_depth):0]   fifo_count
);

  localparam int unsigned ptr_w = $clog2(fifo_depth);
  localparam int unsigned cnt_w = ptr_w + 1;

  logic [fifo_width-1:0] mem [fifo_depth];
  logic [ptr_w-1:0]      wr_ptr;
  logic [ptr_w-1:0]      rd_ptr;

  logic                  wr_acc_c;
  logic                  rd_acc_c;
  logic [cnt_w-1:0]      count_next_c;

  // Accept decisions use the registered flags only.
  always_comb begin
    wr_acc_c     = fifo_write & ~fifo_full;
    rd_acc_c     = fifo_read & ~fifo_empty;
    count_next_c = fifo_count;
    if (wr_acc_c && !rd_acc_c) begin
      count_next_c = fifo_count + cnt_w'(1);
    end else if (rd_acc_c && !wr_acc_c) begin
      count_next_c = fifo_count - cnt_w'(1);
    end
  end

  // Storage array is never cleared; writes are suppressed while in reset.
  always_ff @(posedge clk) begin
    if (rstn && wr_acc_c) begin
      mem[wr_ptr] <= fifo_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      fifo_empty    <= 1'b1;
      fifo_full     <= 1'b0;
      fifo_data_out <= '0;
    end else begin
      if (wr_acc_c) begin
        wr_ptr <= wr_ptr + ptr_w'(1);
      end
      if (rd_acc_c) begin
        fifo_data_out <= mem[rd_ptr];
        rd_ptr        <= rd_ptr + ptr_w'(1);
      end
      fifo_count <= count_next_c;
      fifo_empty <= (count_next_c == '0);
      fifo_full  <= (count_next_c == cnt_w'(fifo_depth));
    end
  end

endmodule

// File: tb/tb_sync_fifo_buffer.sv
// Directed self-checking bench for sync_fifo_buffer (depth 8, width 8).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_sync_fifo_buffer;

  logic       clk;
  logic       rstn;
  logic [7:0] fifo_data_in;
  logic       fifo_write;
  logic       fifo_full;
  logic       fifo_read;
  logic       fifo_empty;
  logic [7:0] fifo_data_out;
  logic [3:0] fifo_count;

  int checks = 0;
  int errors = 0;

  sync_fifo_buffer #(.fifo_depth(8), .fifo_width(8)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .fifo_data_in  (fifo_data_in),
    .fifo_write    (fifo_write),
    .fifo_full     (fifo_full),
    .fifo_read     (fifo_read),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_count    (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [7:0] dout, input logic [3:0] cnt,
                             input logic emp, input logic ful);
    check({tag, "_dout"}, 32'(fifo_data_out), 32'(dout));
    check({tag, "_count"}, 32'(fifo_count), 32'(cnt));
    check({tag, "_empty"}, 32'(fifo_empty), 32'(emp));
    check({tag, "_full"}, 32'(fifo_full), 32'(ful));
  endtask

  task automatic push(input logic [7:0] d);
    fifo_write = 1'b1;
    fifo_data_in = d;
    tick();
    fifo_write = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_d;
    logic [7:0] last_d;
    int pushed;
    int popped;
    int cyc;
    bit wa;
    bit ra;

    rstn = 1'b0;
    fifo_write = 1'b0;
    fifo_read = 1'b0;
    fifo_data_in = 8'h00;

    // Reset and idle after release
    tick();
    tick();
    check_state("reset", 8'h00, 4'd0, 1'b1, 1'b0);
    rstn = 1'b1;
    tick();
    tick();
    check_state("idle", 8'h00, 4'd0, 1'b1, 1'b0);

    // Fill 0x01..0x08
    fifo_write = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      fifo_data_in = 8'(i);
      tick();
      check_state("fill", 8'h00, 4'(i), 1'b0, (i == 8));
    end
    fifo_write = 1'b0;

    // Overflow write is dropped
    push(8'hAA);
    check_state("ovf", 8'h00, 4'd8, 1'b0, 1'b1);

    // Drain returns the original eight words
    fifo_read = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check_state("drain", 8'(i), 4'(8 - i), (i == 8), 1'b0);
    end

    // Underflow: read with empty holds data
    tick();
    tick();
    check_state("udf", 8'h08, 4'd0, 1'b1, 1'b0);
    fifo_read = 1'b0;

    // Simultaneous with 3 stored
    push(8'h10);
    push(8'h11);
    push(8'h12);
    fifo_write = 1'b1;
    fifo_read = 1'b1;
    fifo_data_in = 8'h55;
    tick(); check_state("sim0", 8'h10, 4'd3, 1'b0, 1'b0);
    tick(); check_state("sim1", 8'h11, 4'd3, 1'b0, 1'b0);
    tick(); check_state("sim2", 8'h12, 4'd3, 1'b0, 1'b0);
    tick(); check_state("sim3", 8'h55, 4'd3, 1'b0, 1'b0);
    fifo_write = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_state("simdrain", 8'h55, 4'(3 - i), (i == 3), 1'b0);
    end
    fifo_read = 1'b0;

    // Full with write+read: only the read happens
    for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
    check("full_before", 32'(fifo_full), 32'd1);
    fifo_write = 1'b1;
    fifo_read = 1'b1;
    fifo_data_in = 8'hEE;
    tick();
    check_state("fullwr", 8'h20, 4'd7, 1'b0, 1'b0);
    fifo_write = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check_state("fulldrain", 8'(8'h20 + i), 4'(7 - i), (i == 7), 1'b0);
    end

    // Empty with write+read: only the write happens, no bypass
    fifo_write = 1'b1;
    fifo_data_in = 8'h77;
    tick();
    check_state("emptywr", 8'h27, 4'd1, 1'b0, 1'b0);
    fifo_write = 1'b0;
    tick();
    check_state("emptyrd", 8'h77, 4'd0, 1'b1, 1'b0);
    fifo_read = 1'b0;

    // Random stream of 20 words against a reference queue
    pushed = 0;
    popped = 0;
    cyc = 0;
    last_d = 8'h77;
    while ((popped < 20) && (cyc < 600)) begin
      fifo_write = (pushed < 20) && ($urandom_range(0, 1) == 1);
      fifo_read = ($urandom_range(0, 2) != 0);
      fifo_data_in = 8'($urandom);
      wa = fifo_write && (q.size() < 8);
      ra = fifo_read && (q.size() > 0);
      exp_d = fifo_data_in;
      tick();
      if (ra) begin
        last_d = q.pop_front();
        popped++;
      end
      if (wa) begin
        q.push_back(exp_d);
        pushed++;
      end
      check("rnd_dout", 32'(fifo_data_out), 32'(last_d));
      check("rnd_count", 32'(fifo_count), 32'(q.size()));
      cyc++;
    end
    fifo_write = 1'b0;
    fifo_read = 1'b0;
    check("rnd_done", 32'(popped), 32'd20);

    // Mid-operation reset discards stored words
    for (int i = 0; i < 5; i++) push(8'(8'h90 + i));
    check("pre_rst_count", 32'(fifo_count), 32'd5);
    rstn = 1'b0;
    fifo_read = 1'b1;
    tick();
    rstn = 1'b1;
    check_state("midrst", 8'h00, 4'd0, 1'b1, 1'b0);
    tick();
    tick();
    check_state("postrst_rd", 8'h00, 4'd0, 1'b1, 1'b0);
    fifo_read = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
